// File: rtl/alu_unit.sv
// Registered WIDTH-bit ALU: FWD / ADD / AND / OR with registered ZERO and CARRY flags.
// All outputs come straight from flops, one clock after operands are sampled.
module alu_unit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    input  logic [2:0]       aluop,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry
);

    typedef enum logic [2:0] {
        OP_FWD = 3'b000,
        OP_ADD = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011
    } alu_op_t;

    logic [WIDTH-1:0] and_bits;
    logic [WIDTH-1:0] or_bits;
    logic [WIDTH:0]   sum_full;

    logic [WIDTH-1:0] result_reg;
    logic [WIDTH-1:0] result_next;
    logic             zero_reg;
    logic             zero_next;
    logic             carry_reg;
    logic             carry_next;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_logic_bits
            assign and_bits[gi] = operand1[gi] & operand2[gi];
            assign or_bits[gi]  = operand1[gi] | operand2[gi];
        end
    endgenerate

    // Extend both operands by one bit so the top bit of the sum is the carry-out.
    assign sum_full = {1'b0, operand1} + {1'b0, operand2};

    always_comb begin
        result_next = '0;
        carry_next  = 1'b0;
        case (aluop)
            OP_FWD: result_next = operand2;
            OP_ADD: begin
                result_next = sum_full[WIDTH-1:0];
                carry_next  = sum_full[WIDTH];
            end
            OP_AND: result_next = and_bits;
            OP_OR:  result_next = or_bits;
            default: begin
                result_next = '0;
                carry_next  = 1'b0;
            end
        endcase
        // Derived from the same value that loads result, so flag and data never disagree.
        zero_next = (result_next == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            result_reg <= '0;
            zero_reg   <= 1'b1;
            carry_reg  <= 1'b0;
        end else begin
            result_reg <= result_next;
            zero_reg   <= zero_next;
            carry_reg  <= carry_next;
        end
    end

    assign result = result_reg;
    assign zero   = zero_reg;
    assign carry  = carry_reg;

endmodule

// File: tb/tb_alu_unit.sv
// Scoreboard bench for alu_unit: expected results are queued when stimulus is
// driven and popped when the registered outputs appear one edge later.
module tb_alu_unit;

    localparam int WIDTH = 8;

    logic             clk;
    logic             reset;
    logic [WIDTH-1:0] operand1;
    logic [WIDTH-1:0] operand2;
    logic [2:0]       aluop;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             carry;

    int compared_cnt;
    int mismatch_cnt;

    typedef struct {
        logic [WIDTH-1:0] res;
        logic             z;
        logic             c;
        string            tag;
    } exp_t;

    exp_t exp_q[$];
    exp_t last_exp;

    alu_unit #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .operand1 (operand1),
        .operand2 (operand2),
        .aluop    (aluop),
        .result   (result),
        .zero     (zero),
        .carry    (carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared_cnt++;
        if (observed !== expected) begin
            mismatch_cnt++;
            $display("FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Reference model written from the opcode table, independent of the RTL.
    function automatic exp_t model(input logic rst, input logic [2:0] op,
                                   input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input string tag);
        exp_t e;
        logic [WIDTH:0] s;
        e.tag = tag;
        e.c   = 1'b0;
        s     = {1'b0, a} + {1'b0, b};
        if (rst) begin
            e.res = '0;
        end else begin
            case (op)
                3'b000: e.res = b;
                3'b001: begin e.res = s[WIDTH-1:0]; e.c = s[WIDTH]; end
                3'b010: e.res = a & b;
                3'b011: e.res = a | b;
                default: e.res = '0;
            endcase
        end
        e.z = (e.res == '0);
        return e;
    endfunction

    // Drive one transaction, queue its expectation, then pop and compare after the edge.
    task automatic apply(input string tag, input logic rst, input logic [2:0] op,
                         input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        exp_t e;
        reset    = rst;
        aluop    = op;
        operand1 = a;
        operand2 = b;
        exp_q.push_back(model(rst, op, a, b, tag));
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check_val({e.tag, ".result"}, 32'(result), 32'(e.res));
        check_val({e.tag, ".zero"},   32'(zero),   32'(e.z));
        check_val({e.tag, ".carry"},  32'(carry),  32'(e.c));
        $display("txn %-12s rst=%0b op=%03b a=%02h b=%02h -> result=%02h zero=%0b carry=%0b",
                 e.tag, rst, op, a, b, result, zero, carry);
        last_exp = e;
    endtask

    initial begin
        compared_cnt = 0;
        mismatch_cnt = 0;
        reset    = 1'b1;
        aluop    = 3'b001;
        operand1 = 8'h5A;
        operand2 = 8'hC3;
        @(negedge clk);

        apply("reset0", 1'b1, 3'b001, 8'h5A, 8'hC3);
        apply("reset1", 1'b1, 3'b011, 8'hFF, 8'hFF);

        apply("add_1_2",   1'b0, 3'b001, 8'h01, 8'h02);
        apply("add_5_2",   1'b0, 3'b001, 8'h05, 8'h02);
        apply("add_5_4",   1'b0, 3'b001, 8'h05, 8'h04);
        apply("add_wrap",  1'b0, 3'b001, 8'hFF, 8'h01);
        apply("add_ffff",  1'b0, 3'b001, 8'hFF, 8'hFF);
        apply("add_80_7f", 1'b0, 3'b001, 8'h80, 8'h7F);

        apply("and_5_4",   1'b0, 3'b010, 8'h05, 8'h04);
        apply("or_5_4",    1'b0, 3'b011, 8'h05, 8'h04);
        apply("fwd_5_4",   1'b0, 3'b000, 8'h05, 8'h04);

        apply("fwd_a0_04", 1'b0, 3'b000, 8'hA0, 8'h04);
        apply("fwd_a0_0a", 1'b0, 3'b000, 8'hA0, 8'h0A);
        apply("fwd_f0_0a", 1'b0, 3'b000, 8'hF0, 8'h0A);
        apply("fwd_zero",  1'b0, 3'b000, 8'hFF, 8'h00);

        apply("and_f0_0a", 1'b0, 3'b010, 8'hF0, 8'h0A);
        apply("rsv_101",   1'b0, 3'b101, 8'h37, 8'hC9);
        apply("rsv_100",   1'b0, 3'b100, 8'hFF, 8'hFF);
        apply("rsv_111",   1'b0, 3'b111, 8'h01, 8'h80);

        // Outputs must hold when inputs move between edges.
        apply("pre_hold",  1'b0, 3'b011, 8'h12, 8'h21);
        operand1 = 8'hFF;
        operand2 = 8'h01;
        aluop    = 3'b001;
        #3;
        check_val("hold.result", 32'(result), 32'(last_exp.res));
        check_val("hold.zero",   32'(zero),   32'(last_exp.z));
        check_val("hold.carry",  32'(carry),  32'(last_exp.c));

        // Reset wins over an ADD with carry; first release edge loads normally.
        apply("add_pre",   1'b0, 3'b001, 8'h10, 8'h20);
        apply("rst_add",   1'b1, 3'b001, 8'hFF, 8'h02);
        apply("post_rst",  1'b0, 3'b001, 8'hFF, 8'h02);

        for (int i = 0; i < 40; i++) begin
            apply($sformatf("rand%0d", i), ($urandom_range(0, 15) == 0),
                  3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared_cnt, mismatch_cnt);
        $finish;
    end

endmodule
